full_bridge_gate_driver: RTL and testbench



---
 rtl/full_bridge_gate_driver.sv | 146 ++++++++++++++
 tb/tb_full_bridge_gate_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_bridge_gate_driver.sv
// Full-bridge gate driver: maps the controller's sigma to the four MOSFET gates with
// dead-time insertion on every polarity change, minimum on-time, enable and sticky fault.
module full_bridge_gate_driver #(
    parameter int MIN_ON = 40,
    parameter int DT_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic             i_clock,
    input  logic             i_RESET,
    input  logic             i_sigma,
    input  logic             i_enable,
    input  logic             i_fault,
    input  logic [DT_W-1:0]  i_deadtime,
    output logic [3:0]       o_MOSFET,
    output logic             o_sigma_applied,
    output logic             o_dead,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_switch_count
);

    localparam int ON_W = (MIN_ON < 2) ? 1 : $clog2(MIN_ON + 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_ON_P = 2'd2;
    localparam logic [1:0] ST_ON_N = 2'd3;

    localparam logic [3:0] GATES_OFF  = 4'b0000;
    localparam logic [3:0] GATES_ON_P = 4'b1001;
    localparam logic [3:0] GATES_ON_N = 4'b0110;

    localparam logic [ON_W-1:0] ON_MAX = ON_W'(MIN_ON);
    localparam logic [ON_W-1:0] ON_ONE = ON_W'(1);

    logic [1:0]       state_q,         state_d;
    logic             target_q,        target_d;
    logic [DT_W-1:0]  dead_cnt_q,      dead_cnt_d;
    logic [ON_W-1:0]  on_cnt_q,        on_cnt_d;
    logic [3:0]       mosfet_q,        mosfet_d;
    logic             sigma_applied_q, sigma_applied_d;
    logic             dead_q,          dead_d;
    logic             fault_q,         fault_d;
    logic [CNT_W-1:0] switch_count_q,  switch_count_d;

    logic [DT_W-1:0]  dead_load;
    logic             on_done;

    // A programmed dead time of zero still yields one all-off cycle.
    assign dead_load = (i_deadtime == '0) ? DT_W'(1) : i_deadtime;
    assign on_done   = (on_cnt_q == ON_MAX);

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        dead_cnt_d      = dead_cnt_q;
        on_cnt_d        = on_cnt_q;
        sigma_applied_d = sigma_applied_q;
        switch_count_d  = switch_count_q;

        if (i_fault) begin
            fault_d = 1'b1;
        end else if (!i_enable) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        if (i_fault || !i_enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (!fault_q) begin
                        target_d   = i_sigma;
                        dead_cnt_d = dead_load;
                        state_d    = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_q <= DT_W'(1)) begin
                        state_d         = target_q ? ST_ON_P : ST_ON_N;
                        sigma_applied_d = target_q;
                        switch_count_d  = switch_count_q + CNT_W'(1);
                        on_cnt_d        = ON_ONE;
                    end else begin
                        dead_cnt_d = dead_cnt_q - DT_W'(1);
                    end
                end
                ST_ON_P, ST_ON_N: begin
                    // Sigma is only looked at once the minimum on-time has elapsed.
                    if (on_done && (i_sigma != sigma_applied_q)) begin
                        target_d   = i_sigma;
                        dead_cnt_d = dead_load;
                        state_d    = ST_DEAD;
                    end else if (!on_done) begin
                        on_cnt_d = on_cnt_q + ON_ONE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Gate pattern decoded from the next state so the pins follow the state entered at the edge.
    always_comb begin
        case (state_d)
            ST_ON_P: mosfet_d = GATES_ON_P;
            ST_ON_N: mosfet_d = GATES_ON_N;
            default: mosfet_d = GATES_OFF;
        endcase
        dead_d = (state_d == ST_DEAD);
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q         <= ST_OFF;
            target_q        <= 1'b1;
            dead_cnt_q      <= '0;
            on_cnt_q        <= '0;
            mosfet_q        <= GATES_OFF;
            sigma_applied_q <= 1'b1;
            dead_q          <= 1'b0;
            fault_q         <= 1'b0;
            switch_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            dead_cnt_q      <= dead_cnt_d;
            on_cnt_q        <= on_cnt_d;
            mosfet_q        <= mosfet_d;
            sigma_applied_q <= sigma_applied_d;
            dead_q          <= dead_d;
            fault_q         <= fault_d;
            switch_count_q  <= switch_count_d;
        end
    end

    assign o_MOSFET        = mosfet_q;
    assign o_sigma_applied = sigma_applied_q;
    assign o_dead          = dead_q;
    assign o_fault         = fault_q;
    assign o_switch_count  = switch_count_q;

endmodule

// File: tb/tb_full_bridge_gate_driver.sv
// Bench for full_bridge_gate_driver: directed scenarios plus random stimulus, all compared
// against a behavioural model of the bridge kept here in the bench.
module tb_full_bridge_gate_driver;

    localparam int MIN_ON = 40;
    localparam int DT_W   = 8;
    localparam int CNT_W  = 5;
    localparam int BW     = 7 + CNT_W;

    logic             clk;
    logic             i_RESET;
    logic             i_sigma;
    logic             i_enable;
    logic             i_fault;
    logic [DT_W-1:0]  i_deadtime;
    logic [3:0]       o_MOSFET;
    logic             o_sigma_applied;
    logic             o_dead;
    logic             o_fault;
    logic [CNT_W-1:0] o_switch_count;

    int errors = 0;
    int checks = 0;

    full_bridge_gate_driver #(.MIN_ON(MIN_ON), .DT_W(DT_W), .CNT_W(CNT_W)) dut (
        .i_clock(clk), .i_RESET(i_RESET), .i_sigma(i_sigma), .i_enable(i_enable),
        .i_fault(i_fault), .i_deadtime(i_deadtime), .o_MOSFET(o_MOSFET),
        .o_sigma_applied(o_sigma_applied), .o_dead(o_dead), .o_fault(o_fault),
        .o_switch_count(o_switch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 = bridge off, 1 = dead time running, 2 = conducting with polarity m_app.
    int m_mode, m_left, m_age, m_cnt;
    bit m_tgt, m_app, m_fault;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_age = 0; m_cnt = 0;
        m_tgt = 1; m_app = 1; m_fault = 0;
    endtask

    task automatic model_step();
        bit nf;
        int dt;
        nf = i_fault ? 1'b1 : (!i_enable ? 1'b0 : m_fault);
        dt = (i_deadtime == 0) ? 1 : int'(i_deadtime);
        if (i_fault || !i_enable) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (!m_fault) begin m_tgt = i_sigma; m_left = dt; m_mode = 1; end
        end else if (m_mode == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_mode = 2; m_app = m_tgt; m_cnt = (m_cnt + 1) % (1 << CNT_W); m_age = 1;
            end
        end else begin
            if (m_age >= MIN_ON && i_sigma != m_app) begin
                m_tgt = i_sigma; m_left = dt; m_mode = 1;
            end else begin
                m_age = m_age + 1;
            end
        end
        m_fault = nf;
    endtask

    function automatic logic [BW-1:0] exp_bundle();
        logic [3:0] g;
        g = (m_mode == 2) ? (m_app ? 4'b1001 : 4'b0110) : 4'b0000;
        return {g, m_app, (m_mode == 1), m_fault, CNT_W'(m_cnt)};
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {o_MOSFET, o_sigma_applied, o_dead, o_fault, o_switch_count};
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Shoot-through scoreboard, watched on every falling edge.
    always @(negedge clk) begin
        if (i_RESET) begin
            checks++;
            if (o_MOSFET === 4'b1100 || o_MOSFET === 4'b0011 || $isunknown(o_MOSFET)) begin
                errors++;
                $display("FAIL shoot_through gates=%b at %0t", o_MOSFET, $time);
            end
        end
    end

    task automatic test_reset();
        i_RESET = 0; i_sigma = 1; i_enable = 0; i_fault = 0; i_deadtime = 10;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_bundle() !== {4'b0000, 1'b1, 1'b0, 1'b0, CNT_W'(0)}) begin
            errors++; $display("FAIL reset_values got=%b exp=%b", dut_bundle(), {4'b0000, 3'b100, CNT_W'(0)});
        end
        i_RESET = 1;
    endtask

    task automatic test_startup();
        i_enable = 1; i_sigma = 1; i_deadtime = 10;
        for (int k = 1; k <= 11; k++) begin
            step();
            checks++;
            if (dut_bundle() !== exp_bundle()) begin
                errors++; $display("FAIL startup step=%0d got=%b exp=%b", k, dut_bundle(), exp_bundle());
            end
        end
        checks++;
        if (o_MOSFET !== 4'b1001 || o_switch_count !== CNT_W'(1)) begin
            errors++; $display("FAIL startup_on gates=%b cnt=%0d exp 1001/1", o_MOSFET, o_switch_count);
        end
    endtask

    task automatic test_transition();
        repeat (MIN_ON + 2) step();
        i_sigma = 0; i_deadtime = 5;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (dut_bundle() !== exp_bundle()) begin
                errors++; $display("FAIL transition step=%0d got=%b exp=%b", k, dut_bundle(), exp_bundle());
            end
            if (k <= 5) begin
                checks++;
                if (o_MOSFET !== 4'b0000 || o_dead !== 1'b1) begin
                    errors++; $display("FAIL transition_dead step=%0d gates=%b dead=%b exp 0000/1", k, o_MOSFET, o_dead);
                end
            end
        end
        checks++;
        if (o_MOSFET !== 4'b0110 || o_switch_count !== CNT_W'(2) || o_sigma_applied !== 1'b0) begin
            errors++; $display("FAIL transition_on gates=%b cnt=%0d app=%b exp 0110/2/0", o_MOSFET, o_switch_count, o_sigma_applied);
        end
    endtask

    task automatic test_glitch();
        int n;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            i_sigma = (k >= 10 && k < 13);
            step(); n++;
            checks++;
            if (o_MOSFET !== 4'b0110 || dut_bundle() !== exp_bundle()) begin
                errors++; $display("FAIL glitch n=%0d got=%b exp=%b", n, dut_bundle(), exp_bundle());
            end
        end
        i_sigma = 1;
        while (!o_dead && n < 60) begin step(); n++; end
        checks++;
        if (n != MIN_ON) begin
            errors++; $display("FAIL min_on_hold dead_after=%0d exp=%0d", n, MIN_ON);
        end
    endtask

    task automatic test_dead_ignore();
        int n;
        i_sigma = 0;
        n = 0;
        while (o_MOSFET === 4'b0000 && n < 20) begin step(); n++; end
        checks++;
        if (o_MOSFET !== 4'b1001 || dut_bundle() !== exp_bundle()) begin
            errors++; $display("FAIL dead_latched_target got=%b exp=%b", dut_bundle(), exp_bundle());
        end
        n = 0;
        while (!o_dead && n < 60) begin step(); n++; end
        checks++;
        if (n != MIN_ON) begin
            errors++; $display("FAIL retransition dead_after=%0d exp=%0d", n, MIN_ON);
        end
    endtask

    task automatic test_fault();
        int n;
        i_sigma = 1; n = 0;
        while (o_MOSFET !== 4'b1001 && n < 120) begin step(); n++; end
        checks++;
        if (o_MOSFET !== 4'b1001) begin
            errors++; $display("FAIL fault_setup gates=%b exp=1001", o_MOSFET);
        end
        i_fault = 1; step(); i_fault = 0;
        checks++;
        if (o_MOSFET !== 4'b0000 || o_fault !== 1'b1 || dut_bundle() !== exp_bundle()) begin
            errors++; $display("FAIL fault_trip got=%b exp=%b", dut_bundle(), exp_bundle());
        end
        repeat (5) step();
        checks++;
        if (o_MOSFET !== 4'b0000 || o_fault !== 1'b1 || o_dead !== 1'b0) begin
            errors++; $display("FAIL fault_sticky gates=%b fault=%b dead=%b exp 0000/1/0", o_MOSFET, o_fault, o_dead);
        end
        i_enable = 0; step();
        checks++;
        if (o_fault !== 1'b0 || dut_bundle() !== exp_bundle()) begin
            errors++; $display("FAIL fault_clear got=%b exp=%b", dut_bundle(), exp_bundle());
        end
        i_enable = 1; step();
        checks++;
        if (o_dead !== 1'b1 || o_MOSFET !== 4'b0000) begin
            errors++; $display("FAIL restart_dead dead=%b gates=%b exp 1/0000", o_dead, o_MOSFET);
        end
    endtask

    task automatic test_dt_zero();
        int n;
        n = 0;
        while (o_MOSFET === 4'b0000 && n < 20) begin step(); n++; end
        i_deadtime = 0; i_sigma = 0; n = 0;
        while (!o_dead && n < 60) begin step(); n++; end
        step();
        checks++;
        if (o_MOSFET !== 4'b0110 || o_dead !== 1'b0 || dut_bundle() !== exp_bundle()) begin
            errors++; $display("FAIL dt_zero got=%b exp=%b", dut_bundle(), exp_bundle());
        end
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] prev;
        bit wrapped;
        wrapped = 0;
        for (int t = 0; t < 40 && !wrapped; t++) begin
            prev = o_switch_count;
            i_sigma = ~o_sigma_applied;
            for (int n = 0; n < 60 && o_switch_count == prev; n++) begin
                step();
                checks++;
                if (dut_bundle() !== exp_bundle()) begin
                    errors++; $display("FAIL wrap_track got=%b exp=%b", dut_bundle(), exp_bundle());
                end
            end
            if (prev == {CNT_W{1'b1}}) begin
                wrapped = 1;
                checks++;
                if (o_switch_count !== '0) begin
                    errors++; $display("FAIL count_wrap cnt=%0d exp=0", o_switch_count);
                end
            end
        end
        checks++;
        if (!wrapped) begin
            errors++; $display("FAIL wrap_reached cnt=%0d exp wrap", o_switch_count);
        end
    endtask

    task automatic test_reset_mid_dead();
        int n;
        i_deadtime = 8; i_sigma = ~o_sigma_applied; n = 0;
        while (!o_dead && n < 60) begin step(); n++; end
        step(); step();
        i_RESET = 0;
        #1;
        checks++;
        if (dut_bundle() !== {4'b0000, 1'b1, 1'b0, 1'b0, CNT_W'(0)}) begin
            errors++; $display("FAIL reset_mid_dead got=%b exp=%b", dut_bundle(), {4'b0000, 3'b100, CNT_W'(0)});
        end
        model_reset();
        @(posedge clk); #1;
        i_RESET = 1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) i_sigma = ~i_sigma;
            i_enable   = ($urandom_range(0, 63) != 0);
            i_fault    = ($urandom_range(0, 127) == 0);
            i_deadtime = DT_W'($urandom_range(0, 12));
            step();
            checks++;
            if (dut_bundle() !== exp_bundle()) begin
                errors++; $display("FAIL random cyc=%0d got=%b exp=%b", k, dut_bundle(), exp_bundle());
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_transition();
        test_glitch();
        test_dead_ignore();
        test_fault();
        test_dt_zero();
        test_wrap();
        test_reset_mid_dead();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
